// File: rtl/imm_gen_pipe.sv
// Immediate extender with valid/ready input, 2-entry output buffer and a
// saturating illegal-instruction counter. Immediates are formed before storage.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_AUTO = 3'd6,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    logic [6:0]  opcode;
    logic        sgn;
    logic [2:0]  res_fmt;
    logic        res_ill;
    logic [63:0] imm64;
    entry_t      new_entry;
    entry_t      slot0;
    entry_t      slot1;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign opcode = in_instr[6:0];
    assign sgn    = in_instr[31];

    always_comb begin
        res_fmt = in_sel;
        res_ill = 1'b0;
        if (in_sel == FMT_AUTO) begin
            unique case (opcode)
                7'b0010011, 7'b0000011, 7'b1100111: res_fmt = FMT_I;
                7'b1110011: res_fmt = in_instr[14] ? FMT_Z : FMT_I;
                7'b0100011: res_fmt = FMT_S;
                7'b1100011: res_fmt = FMT_B;
                7'b0110111, 7'b0010111: res_fmt = FMT_U;
                7'b1101111: res_fmt = FMT_J;
                7'b0110011: res_fmt = FMT_NONE;
                default: begin
                    res_fmt = FMT_NONE;
                    res_ill = 1'b1;
                end
            endcase
        end else if (in_sel == FMT_NONE) begin
            res_ill = 1'b1;
        end
    end

    // Built at 64 bits and truncated so one expression serves both XLEN values.
    always_comb begin
        imm64 = '0;
        case (res_fmt)
            FMT_I:   imm64 = {{52{sgn}}, in_instr[31:20]};
            FMT_S:   imm64 = {{52{sgn}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm64 = {{51{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            FMT_U:   imm64 = {{32{sgn}}, in_instr[31:12], 12'b0};
            FMT_J:   imm64 = {{43{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            FMT_Z:   imm64 = {59'b0, in_instr[19:15]};
            default: imm64 = '0;
        endcase
    end

    always_comb begin
        new_entry.imm     = imm64[XLEN-1:0];
        new_entry.fmt     = res_fmt;
        new_entry.illegal = res_ill;
        new_entry.instr   = in_instr;
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // slot0 is always the head; slot1 only holds data when count is 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= new_entry;
                    end else begin
                        slot1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: slot0 <= new_entry;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (push && res_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = slot0.imm;
    assign out_fmt     = slot0.fmt;
    assign out_illegal = slot0.illegal;
    assign out_instr   = slot0.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance, each with its own expected queue and monitor.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    ent_t q0[$];
    ent_t q1[$];

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, out_ill0, cnt_clr0;
    logic [31:0] in_instr0, out_instr0, out_imm0;
    logic [2:0]  in_sel0, out_fmt0;
    logic [15:0] cnt0;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_ill1, cnt_clr1;
    logic [31:0] in_instr1, out_instr1;
    logic [63:0] out_imm1;
    logic [2:0]  in_sel1, out_fmt1;
    logic [1:0]  cnt1;
    logic        flush1 = 1'b0;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_instr(in_instr0), .in_sel(in_sel0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_imm(out_imm0), .out_fmt(out_fmt0),
        .out_illegal(out_ill0), .out_instr(out_instr0), .illegal_cnt(cnt0), .cnt_clr(cnt_clr0)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_instr(in_instr1), .in_sel(in_sel1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_imm(out_imm1), .out_fmt(out_fmt1),
        .out_illegal(out_ill1), .out_instr(out_instr1), .illegal_cnt(cnt1), .cnt_clr(cnt_clr1)
    );

    vec_t vecs[17] = '{
        '{3'd0, 32'hFFF00093, 64'h00000000FFFFFFFF, 3'd0, 1'b0},
        '{3'd6, 32'hFE000EE3, 64'h00000000FFFFFFFC, 3'd2, 1'b0},
        '{3'd6, 32'h3002D073, 64'h0000000000000005, 3'd5, 1'b0},
        '{3'd1, 32'hFE112C23, 64'h00000000FFFFFFF8, 3'd1, 1'b0},
        '{3'd4, 32'hFFDFF06F, 64'h00000000FFFFFFFC, 3'd4, 1'b0},
        '{3'd3, 32'h12345037, 64'h0000000012345000, 3'd3, 1'b0},
        '{3'd6, 32'h00000033, 64'h0000000000000000, 3'd7, 1'b0},
        '{3'd7, 32'hFFF00093, 64'h0000000000000000, 3'd7, 1'b1},
        '{3'd5, 32'h000F8073, 64'h000000000000001F, 3'd5, 1'b0},
        '{3'd6, 32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1},
        '{3'd2, 32'h00000863, 64'h0000000000000010, 3'd2, 1'b0},
        '{3'd6, 32'h80002083, 64'h00000000FFFFF800, 3'd0, 1'b0},
        '{3'd6, 32'h00000073, 64'h0000000000000000, 3'd0, 1'b0},
        '{3'd6, 32'h12345017, 64'h0000000012345000, 3'd3, 1'b0},
        '{3'd6, 32'h8000006F, 64'h00000000FFF00000, 3'd4, 1'b0},
        '{3'd6, 32'hFE112C23, 64'h00000000FFFFFFF8, 3'd1, 1'b0},
        '{3'd6, 32'h00000013, 64'h0000000000000000, 3'd0, 1'b0}
    };

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: condition not met", name);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [2:0] sel, input logic [31:0] instr,
                                 input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        ent_t e;
        int guard = 0;
        e.imm = imm; e.fmt = fmt; e.ill = ill; e.instr = instr;
        if (d == 0) begin
            in_valid0 = 1'b1; in_sel0 = sel; in_instr0 = instr;
        end else begin
            in_valid1 = 1'b1; in_sel1 = sel; in_instr1 = instr;
        end
        while (((d == 0) ? !in_ready0 : !in_ready1) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) begin
            fail("accept_timeout");
            in_valid0 = 1'b0;
            in_valid1 = 1'b0;
            return;
        end
        if (d == 0) begin
            q0.push_back(e);
            if (cnt_clr0) exp_cnt0 = 0;
            else if (ill && exp_cnt0 < 65535) exp_cnt0++;
        end else begin
            q1.push_back(e);
            if (cnt_clr1) exp_cnt1 = 0;
            else if (ill && exp_cnt1 < 3) exp_cnt1++;
        end
        @(posedge clk); #1;
        if (d == 0) in_valid0 = 1'b0;
        else        in_valid1 = 1'b0;
    endtask

    task automatic applyVec(input int i);
        applyStimulus(0, vecs[i].sel, vecs[i].instr, vecs[i].imm, vecs[i].fmt, vecs[i].ill);
    endtask

    task automatic drain(input int d);
        int guard = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) fail("drain_timeout");
    endtask

    // Compares the head against the queue front every cycle it is valid, so a
    // stalled head is re-checked for stability; pops only on a real handshake.
    task automatic monitorHead(input int d, input logic v, input logic r, input logic fl,
                               input logic [63:0] imm, input logic [2:0] fmt,
                               input logic ill, input logic [31:0] instr);
        ent_t e;
        if (!v) return;
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            fail($sformatf("d%0d_unexpected_output", d));
            return;
        end
        e = (d == 0) ? q0[0] : q1[0];
        checkOutput($sformatf("d%0d_imm", d), imm, e.imm);
        checkOutput($sformatf("d%0d_fmt", d), {61'b0, fmt}, {61'b0, e.fmt});
        checkOutput($sformatf("d%0d_illegal", d), {63'b0, ill}, {63'b0, e.ill});
        checkOutput($sformatf("d%0d_instr", d), {32'b0, instr}, {32'b0, e.instr});
        if (r && !fl) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    always @(negedge clk)
        if (rst_n) monitorHead(0, out_valid0, out_ready0, flush0, {32'b0, out_imm0}, out_fmt0, out_ill0, out_instr0);

    always @(negedge clk)
        if (rst_n) monitorHead(1, out_valid1, out_ready1, flush1, out_imm1, out_fmt1, out_ill1, out_instr1);

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_sel0 = 3'd0; in_instr0 = '0; out_ready0 = 1'b1; cnt_clr0 = 1'b0;
        in_valid1 = 1'b0; in_sel1 = 3'd0; in_instr1 = '0; out_ready1 = 1'b1; cnt_clr1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        checkOutput("rst_out_valid", out_valid0, 0);
        checkOutput("rst_in_ready", in_ready0, 1);
        checkOutput("rst_out_imm", out_imm0, 0);
        checkOutput("rst_cnt", cnt0, 0);

        applyVec(0);
        checkOutput("latency_out_valid", out_valid0, 1);
        for (int i = 1; i < 17; i++) applyVec(i);
        drain(0);
        checkOutput("cnt_after_vectors", cnt0, exp_cnt0[15:0]);

        // Backpressure: A and B fill the buffer, C waits.
        out_ready0 = 1'b0;
        applyVec(0);
        applyVec(1);
        checkOutput("full_in_ready", in_ready0, 0);
        in_valid0 = 1'b1; in_sel0 = vecs[3].sel; in_instr0 = vecs[3].instr;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("held_in_ready", in_ready0, 0);
        checkOutput("held_out_valid", out_valid0, 1);
        out_ready0 = 1'b1;
        applyVec(3);
        checkOutput("no_bubble_after_c", out_valid0, 1);
        drain(0);

        // Flush at full with a push attempted.
        out_ready0 = 1'b0;
        applyVec(0);
        applyVec(1);
        in_valid0 = 1'b1; in_sel0 = 3'd7; in_instr0 = 32'h0000007F; flush0 = 1'b1;
        @(posedge clk); #1;
        flush0 = 1'b0; in_valid0 = 1'b0; q0.delete();
        checkOutput("flush2_out_valid", out_valid0, 0);
        checkOutput("flush2_in_ready", in_ready0, 1);
        checkOutput("flush2_cnt", cnt0, exp_cnt0[15:0]);

        // Flush at count 1 with an acceptable illegal push: dropped and uncounted.
        applyVec(0);
        in_valid0 = 1'b1; in_sel0 = 3'd7; in_instr0 = 32'h0000007F; flush0 = 1'b1;
        @(posedge clk); #1;
        flush0 = 1'b0; in_valid0 = 1'b0; q0.delete();
        checkOutput("flush1_out_valid", out_valid0, 0);
        checkOutput("flush1_cnt", cnt0, exp_cnt0[15:0]);
        out_ready0 = 1'b1;

        cnt_clr0 = 1'b1;
        applyStimulus(0, 3'd6, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        cnt_clr0 = 1'b0;
        checkOutput("cnt_clr_with_push", cnt0, 0);
        drain(0);

        // Asynchronous reset between edges with the buffer full.
        out_ready0 = 1'b0;
        applyVec(9);
        applyVec(0);
        #2 rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        exp_cnt0 = 0; exp_cnt1 = 0;
        checkOutput("arst_out_valid", out_valid0, 0);
        checkOutput("arst_in_ready", in_ready0, 1);
        checkOutput("arst_out_imm", out_imm0, 0);
        checkOutput("arst_out_fmt", out_fmt0, 0);
        checkOutput("arst_out_illegal", out_ill0, 0);
        checkOutput("arst_out_instr", out_instr0, 0);
        checkOutput("arst_cnt", cnt0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready0 = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1, 3'd6, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
        applyStimulus(1, 3'd0, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        applyStimulus(1, 3'd4, 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        applyStimulus(1, 3'd6, 32'h80002083, 64'hFFFFFFFFFFFFF800, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 3'd6, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        drain(1);
        checkOutput("sat_cnt", cnt1, exp_cnt1[1:0]);
        checkOutput("sat_cnt_value", cnt1, 3);
        cnt_clr1 = 1'b1;
        applyStimulus(1, 3'd6, 32'h0000007F, 64'h0, 3'd7, 1'b1);
        cnt_clr1 = 1'b0;
        checkOutput("sat_cnt_clr", cnt1, 0);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
